// File: rtl/la_parity_frame.sv
// la_parity_frame: streaming frame parity accumulator/checker with a one-deep result register.
// Beat parity is reduced through a 4-ary tree of 4-input XOR cells.
module la_pf_xor4 #(
    parameter string PROP = "DEFAULT"
) (
    input  logic [3:0] a_i,
    output logic       y_o
);
    if (PROP == "DEFAULT") begin : g_flat
        assign y_o = ^a_i;
    end else begin : g_pair
        assign y_o = (a_i[0] ^ a_i[1]) ^ (a_i[2] ^ a_i[3]);
    end
endmodule

module la_parity_frame #(
    parameter int    DW   = 32,
    parameter int    CW   = 8,
    parameter int    ODD  = 0,
    parameter string PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic          in_parity,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_parity,
    output logic          out_error,
    output logic [CW-1:0] out_count,
    output logic          out_sat
);
    localparam int   NL    = ($clog2(DW) + 1) / 2;
    localparam logic ODD_B = (ODD != 0);

    function automatic int lvl_w(int k);
        return (DW + (1 << (2 * k)) - 1) >> (2 * k);
    endfunction

    function automatic int lvl_off(int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) o += lvl_w(i);
        return o;
    endfunction

    localparam int TW = lvl_off(NL + 1);

    // All tree levels packed into one vector: level k occupies [lvl_off(k) +: lvl_w(k)]
    logic [TW-1:0] tree;
    logic          bp;

    assign tree[DW-1:0] = in_data;
    for (genvar k = 0; k < NL; k++) begin : g_lvl
        localparam int WI = lvl_w(k);
        localparam int WO = lvl_w(k + 1);
        localparam int OI = lvl_off(k);
        localparam int OO = lvl_off(k + 1);
        for (genvar j = 0; j < WO; j++) begin : g_grp
            la_pf_xor4 #(.PROP(PROP)) u_xor4 (
                .a_i(4'(tree[OI +: WI] >> (4 * j))),
                .y_o(tree[OO + j])
            );
        end
    end
    assign bp = tree[TW-1];

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t        state_q, state_d;
    logic          acc_q, acc_d, sat_q, sat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d, par_q, par_d, err_q, err_d, osat_q, osat_d;
    logic [CW-1:0] ocnt_q, ocnt_d;
    logic          accept, acc_cur, cnt_max, frame_par;
    logic [CW-1:0] cnt_cur, cnt_inc;

    assign in_ready  = ~valid_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign acc_cur   = (state_q == ACCUM) & acc_q;
    assign cnt_cur   = (state_q == ACCUM) ? cnt_q : '0;
    assign cnt_max   = &cnt_cur;
    assign cnt_inc   = cnt_max ? cnt_cur : cnt_cur + CW'(1);
    assign frame_par = acc_cur ^ bp ^ ODD_B;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        valid_d = valid_q & ~out_ready;
        par_d   = par_q;
        err_d   = err_q;
        ocnt_d  = ocnt_q;
        osat_d  = osat_q;
        if (accept && !in_last) begin
            state_d = ACCUM;
            acc_d   = acc_cur ^ bp;
            cnt_d   = cnt_inc;
            sat_d   = sat_q | cnt_max;
        end else if (accept) begin
            state_d = IDLE;
            acc_d   = 1'b0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            valid_d = 1'b1;
            par_d   = frame_par;
            err_d   = frame_par ^ in_parity;
            ocnt_d  = cnt_inc;
            osat_d  = sat_q | cnt_max;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            ocnt_q  <= '0;
            osat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            par_q   <= par_d;
            err_q   <= err_d;
            ocnt_q  <= ocnt_d;
            osat_q  <= osat_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_parity = par_q;
    assign out_error  = err_q;
    assign out_count  = ocnt_q;
    assign out_sat    = osat_q;
endmodule

// File: tb/tb_la_parity_frame.sv
// tb_la_parity_frame: directed frame vectors against even, odd and 2-bit-counter instances
// sharing one stimulus stream.
module tb_la_parity_frame;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_last, in_parity, out_ready;
    logic [31:0] in_data;
    logic        e_ready, e_valid, e_par, e_err, e_sat;
    logic [7:0]  e_cnt;
    logic        o_ready, o_valid, o_par, o_err, o_sat;
    logic [7:0]  o_cnt;
    logic        s_ready, s_valid, s_par, s_err, s_sat;
    logic [1:0]  s_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    la_parity_frame #(.DW(32), .CW(8), .ODD(0)) u_even (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(e_ready), .in_data(in_data),
        .in_last(in_last), .in_parity(in_parity), .out_valid(e_valid), .out_ready(out_ready),
        .out_parity(e_par), .out_error(e_err), .out_count(e_cnt), .out_sat(e_sat)
    );
    la_parity_frame #(.DW(32), .CW(8), .ODD(1)) u_odd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_ready), .in_data(in_data),
        .in_last(in_last), .in_parity(in_parity), .out_valid(o_valid), .out_ready(out_ready),
        .out_parity(o_par), .out_error(o_err), .out_count(o_cnt), .out_sat(o_sat)
    );
    la_parity_frame #(.DW(32), .CW(2), .ODD(0)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_ready), .in_data(in_data),
        .in_last(in_last), .in_parity(in_parity), .out_valid(s_valid), .out_ready(out_ready),
        .out_parity(s_par), .out_error(s_err), .out_count(s_cnt), .out_sat(s_sat)
    );

    typedef struct {
        int              n;
        logic [5:0][31:0] d;
        logic            par;
        logic            ep, ee;
        logic [7:0]      ec;
        logic            op, oe;
        logic [1:0]      sc;
        logic            ss;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic [31:0] d0, d1, d2, d3, d4, d5, input logic par,
                       input logic ep, ee, input logic [7:0] ec, input logic op, oe,
                       input logic [1:0] sc, input logic ss);
        vec_t v;
        v.n = n;
        v.d = {d5, d4, d3, d2, d1, d0};
        v.par = par;
        v.ep = ep; v.ee = ee; v.ec = ec;
        v.op = op; v.oe = oe;
        v.sc = sc; v.ss = ss;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last, input logic p);
        int w;
        in_valid = 1'b1; in_data = d; in_last = last; in_parity = p;
        w = 0;
        while (!e_ready && w < 50) begin
            tick();
            w++;
        end
        if (!e_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_stall: got in_ready=0 required 1 within 50 cycles");
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_parity = 1'b0; in_data = '0; out_ready = 1'b1;
        //  n  beats                                                                 par ep ee cnt op oe sc ss
        add(1, 32'h1, 0, 0, 0, 0, 0,                                                  1, 1, 0, 1, 0, 1, 1, 0);
        add(3, 32'hF, 32'h1, 32'h3, 0, 0, 0,                                          0, 1, 1, 3, 0, 0, 3, 0);
        add(1, 32'h0, 0, 0, 0, 0, 0,                                                  1, 0, 1, 1, 1, 0, 1, 0);
        add(4, 32'hFFFF_FFFF, 32'h8000_0000, 32'h3, 32'h1234_5678, 0, 0,             1, 0, 1, 4, 1, 0, 3, 1);
        add(6, 32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h7,                             0, 0, 0, 6, 1, 1, 3, 1);
        add(2, 32'hA5A5_A5A5, 32'h0000_0100, 0, 0, 0, 0,                              1, 1, 0, 2, 0, 1, 2, 0);
        tick(); tick();
        chk("rst_valid", 32'(e_valid), 0);
        chk("rst_parity", 32'(e_par), 0);
        chk("rst_error", 32'(e_err), 0);
        chk("rst_count", 32'(e_cnt), 0);
        chk("rst_sat", 32'(s_sat), 0);
        chk("rst_ready", 32'(e_ready), 1);
        reset = 1'b0;
        tick();

        foreach (tbl[i]) begin
            for (int b = 0; b < tbl[i].n; b++) beat(tbl[i].d[b], b == tbl[i].n - 1, tbl[i].par);
            chk($sformatf("v%0d_valid", i), 32'(e_valid), 1);
            chk($sformatf("v%0d_even_par", i), 32'(e_par), 32'(tbl[i].ep));
            chk($sformatf("v%0d_even_err", i), 32'(e_err), 32'(tbl[i].ee));
            chk($sformatf("v%0d_even_cnt", i), 32'(e_cnt), 32'(tbl[i].ec));
            chk($sformatf("v%0d_even_sat", i), 32'(e_sat), 0);
            chk($sformatf("v%0d_odd_par", i), 32'(o_par), 32'(tbl[i].op));
            chk($sformatf("v%0d_odd_err", i), 32'(o_err), 32'(tbl[i].oe));
            chk($sformatf("v%0d_cw2_par", i), 32'(s_par), 32'(tbl[i].ep));
            chk($sformatf("v%0d_cw2_cnt", i), 32'(s_cnt), 32'(tbl[i].sc));
            chk($sformatf("v%0d_cw2_sat", i), 32'(s_sat), 32'(tbl[i].ss));
        end
        tick();
        chk("idle_valid_clear", 32'(e_valid), 0);

        // back-to-back single-beat frames, one per cycle
        beat(32'h1, 1'b1, 1'b1);
        chk("b2b0_par", 32'(e_par), 1);
        chk("b2b0_ready", 32'(e_ready), 1);
        beat(32'h3, 1'b1, 1'b1);
        chk("b2b1_par", 32'(e_par), 0);
        chk("b2b1_err", 32'(e_err), 1);
        chk("b2b1_valid", 32'(e_valid), 1);
        beat(32'h7, 1'b1, 1'b1);
        chk("b2b2_par", 32'(e_par), 1);
        chk("b2b2_cnt", 32'(e_cnt), 1);
        tick();

        // held result under backpressure, then a pending last beat loads on out_ready
        out_ready = 1'b0;
        beat(32'h1, 1'b1, 1'b1);
        chk("hold_valid", 32'(e_valid), 1);
        in_valid = 1'b1; in_data = 32'h3; in_last = 1'b1; in_parity = 1'b1;
        #1;
        chk("hold_ready_low", 32'(e_ready), 0);
        tick(); tick();
        chk("hold_valid_stable", 32'(e_valid), 1);
        chk("hold_par_stable", 32'(e_par), 1);
        chk("hold_err_stable", 32'(e_err), 0);
        chk("hold_cnt_stable", 32'(e_cnt), 1);
        out_ready = 1'b1;
        #1;
        chk("release_ready", 32'(e_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("reload_valid", 32'(e_valid), 1);
        chk("reload_par", 32'(e_par), 0);
        chk("reload_err", 32'(e_err), 1);
        tick();
        chk("reload_clear", 32'(e_valid), 0);

        // reset discards a held result
        out_ready = 1'b0;
        beat(32'h1, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        chk("rst_hold_valid", 32'(e_valid), 0);
        reset = 1'b0;
        out_ready = 1'b1;

        // reset mid-frame leaves no residue
        beat(32'h1, 1'b0, 1'b0);
        beat(32'h4, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk("abort_valid", 32'(e_valid), 0);
        chk("abort_cnt", 32'(e_cnt), 0);
        reset = 1'b0;
        beat(32'h3, 1'b1, 1'b0);
        chk("post_abort_valid", 32'(e_valid), 1);
        chk("post_abort_cnt", 32'(e_cnt), 1);
        chk("post_abort_par", 32'(e_par), 0);
        chk("post_abort_err", 32'(e_err), 0);
        chk("post_abort_odd_par", 32'(o_par), 1);
        chk("post_abort_cw2_cnt", 32'(s_cnt), 1);
        chk("post_abort_cw2_sat", 32'(s_sat), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
